imuldiv_div_arbiter: RTL and testbench

//   Shares one iterative divider (val/rdy req/resp, fn/a[31:0]/b[31:0] -> result[63:0] = {rem,quot})

---
 rtl/imuldiv_div_arbiter_pkg.sv | 17 +
 rtl/imuldiv_div_arbiter_rr_picker.sv | 34 +++
 rtl/imuldiv_div_arbiter.sv | 136 +++++++++++++
 tb/tb_imuldiv_div_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_arbiter_pkg.sv
// imuldiv_div_arbiter_pkg: shared state encoding and datapath widths for the divider arbiter.
// Rev 1.0
`default_nettype none

package imuldiv_div_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DIV_W = 32;
  localparam int RES_W = 64;

endpackage

`default_nettype wire

// File: rtl/imuldiv_div_arbiter_rr_picker.sv
// imuldiv_div_arbiter_rr_picker: combinational round-robin pick starting at ptr.
// Rev 1.0
`default_nettype none

module imuldiv_div_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               any
);

  // Walk priority distances from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(ptr) + k) % NUM_REQ) == j)) begin
          grant_oh    = '0;
          grant_oh[j] = 1'b1;
          grant_idx   = TAG_W'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imuldiv_div_arbiter.sv
// imuldiv_div_arbiter: round-robin sharing of one iterative divider among NUM_REQ ports.
// Rev 1.0 -- optional counters enabled by IMULDIV_DIV_ARB_STATS_EN.
`default_nettype none

module imuldiv_div_arbiter
  import imuldiv_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_val,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic [NUM_REQ-1:0]       req_fn,
  input  logic [DIV_W*NUM_REQ-1:0] req_a,
  input  logic [DIV_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_val,
  input  logic [NUM_REQ-1:0]       resp_rdy,
  output logic [RES_W-1:0]         resp_result,
  output logic                     div_req_val,
  input  logic                     div_req_rdy,
  output logic                     div_req_fn,
  output logic [DIV_W-1:0]         div_req_a,
  output logic [DIV_W-1:0]         div_req_b,
  input  logic                     div_resp_val,
  output logic                     div_resp_rdy,
  input  logic [RES_W-1:0]         div_resp_result
`ifdef IMULDIV_DIV_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]    stat_ops,
  output logic [31:0]              stat_stall
`endif
);

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   rr_ptr, owner, lock_idx, pick_idx, grant_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               lock, pick_any, owner_rdy, req_fire, resp_fire, stall;

  imuldiv_div_arbiter_rr_picker #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W)
  ) u_picker (
    .req      (req_val),
    .ptr      (rr_ptr),
    .grant_oh (pick_oh),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );

  // A stalled grant is frozen so a newly raised higher-priority port cannot steal it.
  assign grant_idx   = lock ? lock_idx : pick_idx;
  assign resp_result = div_resp_result;
  assign stall       = (state == ST_ARB) && pick_any && !div_req_rdy;

  always_comb begin
    state_nxt    = state;
    req_rdy      = '0;
    resp_val     = '0;
    div_req_val  = 1'b0;
    div_req_fn   = 1'b0;
    div_req_a    = '0;
    div_req_b    = '0;
    div_resp_rdy = 1'b0;
    req_fire     = 1'b0;
    resp_fire    = 1'b0;
    owner_rdy    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == TAG_W'(i)) owner_rdy = resp_rdy[i];
    end
    case (state)
      ST_ARB: begin
        div_req_val = pick_any;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (pick_any && (grant_idx == TAG_W'(i))) begin
            div_req_fn = req_fn[i];
            div_req_a  = req_a[DIV_W*i +: DIV_W];
            div_req_b  = req_b[DIV_W*i +: DIV_W];
          end
          if (lock ? (lock_idx == TAG_W'(i)) : pick_oh[i]) req_rdy[i] = pick_any && div_req_rdy;
        end
        req_fire = pick_any && div_req_rdy;
        if (req_fire) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner == TAG_W'(i)) resp_val[i] = div_resp_val;
        end
        div_resp_rdy = owner_rdy;
        resp_fire    = div_resp_val && owner_rdy;
        if (resp_fire) state_nxt = ST_ARB;
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        owner <= grant_idx;
        lock  <= 1'b0;
      end else if (stall) begin
        lock     <= 1'b1;
        lock_idx <= grant_idx;
      end
      if (resp_fire) rr_ptr <= (owner == LAST_IDX) ? '0 : owner + TAG_W'(1);
    end
  end

`ifdef IMULDIV_DIV_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_fire && (owner == TAG_W'(i))) stat_ops[32*i +: 32] <= stat_ops[32*i +: 32] + 32'd1;
      end
      if (stall) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imuldiv_div_arbiter.sv
// tb_imuldiv_div_arbiter: vector table, directed corner sequences and a randomized run against a reference model.
// Rev 1.0
`default_nettype none

module tb_imuldiv_div_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_val, req_rdy, req_fn, resp_val, resp_rdy;
  logic [63:0] req_a, req_b, resp_result, div_resp_result;
  logic        div_req_val, div_req_rdy, div_req_fn, div_resp_val, div_resp_rdy;
  logic [31:0] div_req_a, div_req_b;
`ifdef IMULDIV_DIV_ARB_STATS_EN
  logic [63:0] stat_ops;
  logic [31:0] stat_stall;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  imuldiv_div_arbiter #(.NUM_REQ(2), .TAG_W(1)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn), .req_a(req_a), .req_b(req_b),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result),
    .div_req_val(div_req_val), .div_req_rdy(div_req_rdy), .div_req_fn(div_req_fn),
    .div_req_a(div_req_a), .div_req_b(div_req_b),
    .div_resp_val(div_resp_val), .div_resp_rdy(div_resp_rdy), .div_resp_result(div_resp_result)
`ifdef IMULDIV_DIV_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  typedef struct {
    logic [1:0]  val;
    logic        rdy;
    logic [1:0]  exp_rdy;
    logic        exp_dv;
    logic [31:0] exp_a;
    logic        exp_fn;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] div_ref(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (fn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    req_val = '0; req_fn = '0; req_a = '0; req_b = '0; resp_rdy = '0;
    div_req_rdy = 1'b0; div_resp_val = 1'b0; div_resp_result = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Present the currently driven request with the divider ready; expect port ep to win.
  task automatic issue(input int ep, input logic [31:0] ea);
    div_req_rdy = 1'b1;
    #1;
    chk("grant", req_rdy, 64'(1) << ep);
    chk("grant_a", div_req_a, ea);
    @(posedge clk); #1;
    div_req_rdy = 1'b0;
  endtask

  // Divider answers; non-owner ports are ready while the owner stalls for 'stall' cycles.
  task automatic serve(input int ep, input logic [63:0] res, input int stall);
    logic [1:0] oh;
    oh = 2'(1 << ep);
    div_resp_val = 1'b1;
    div_resp_result = res;
    resp_rdy = ~oh;
    for (int c = 0; c < stall; c++) begin
      #1;
      chk("stall_resp_val", resp_val, oh);
      chk("stall_result", resp_result, res);
      chk("stall_div_resp_rdy", div_resp_rdy, 0);
      chk("stall_no_issue", div_req_val, 0);
      @(posedge clk); #1;
    end
    resp_rdy = oh;
    #1;
    chk("resp_val", resp_val, oh);
    chk("resp_result", resp_result, res);
    chk("div_resp_rdy", div_resp_rdy, 1);
    @(posedge clk); #1;
    div_resp_val = 1'b0;
    resp_rdy = '0;
  endtask

  // Reference model state for the randomized run.
  int          pref, mowner, mlock_port, dlat, fire_port, ep;
  bit          mbusy, mlock, req_fire_l, resp_fire_l, any;
  bit          pend[2];
  logic [31:0] pa[2], pb[2];
  logic        pfn[2];
  logic [63:0] dres;

  initial begin
    vt[0] = '{val: 2'b00, rdy: 1'b1, exp_rdy: 2'b00, exp_dv: 1'b0, exp_a: 32'h0,    exp_fn: 1'b0};
    vt[1] = '{val: 2'b01, rdy: 1'b1, exp_rdy: 2'b01, exp_dv: 1'b1, exp_a: 32'h1111, exp_fn: 1'b0};
    vt[2] = '{val: 2'b10, rdy: 1'b1, exp_rdy: 2'b10, exp_dv: 1'b1, exp_a: 32'h2222, exp_fn: 1'b1};
    vt[3] = '{val: 2'b11, rdy: 1'b1, exp_rdy: 2'b01, exp_dv: 1'b1, exp_a: 32'h1111, exp_fn: 1'b0};
    vt[4] = '{val: 2'b11, rdy: 1'b0, exp_rdy: 2'b00, exp_dv: 1'b1, exp_a: 32'h1111, exp_fn: 1'b0};
    vt[5] = '{val: 2'b10, rdy: 1'b0, exp_rdy: 2'b00, exp_dv: 1'b1, exp_a: 32'h2222, exp_fn: 1'b1};

    // Reset state
    do_reset();
    #1;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_div_req_val", div_req_val, 0);
    chk("rst_div_resp_rdy", div_resp_rdy, 0);

    // Combinational arbitration from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      req_val = vt[v].val; req_fn = 2'b10; req_a = {32'h2222, 32'h1111}; req_b = {32'h5, 32'h3};
      div_req_rdy = vt[v].rdy;
      #1;
      chk("tbl_req_rdy", req_rdy, vt[v].exp_rdy);
      chk("tbl_div_req_val", div_req_val, vt[v].exp_dv);
      chk("tbl_div_req_a", div_req_a, vt[v].exp_a);
      chk("tbl_div_req_fn", div_req_fn, vt[v].exp_fn);
    end

    // Single op on port 0: 100/7 signed -> rem 2, quot 14
    do_reset();
    req_val = 2'b01; req_fn = 2'b01; req_a = {32'h0, 32'd100}; req_b = {32'h0, 32'd7};
    issue(0, 32'd100);
    req_val = 2'b00;
    #1;
    chk("busy_no_rdy", req_rdy, 0);
    chk("busy_no_resp", resp_val, 0);
    @(posedge clk); #1;
    serve(0, {32'd2, 32'd14}, 0);
    #1;
    chk("single_resp_drop", resp_val, 0);

    // Contention and fairness: both ports always valid, alternating grants
    do_reset();
    req_val = 2'b11; req_fn = 2'b00; req_a = {32'd900, 32'd500}; req_b = {32'd7, 32'd9};
    for (int n = 0; n < 6; n++) begin
      ep = n % 2;
      issue(ep, (ep == 0) ? 32'd500 : 32'd900);
      serve(ep, (ep == 0) ? div_ref(0, 500, 9) : div_ref(0, 900, 7), 0);
    end
`ifdef IMULDIV_DIV_ARB_STATS_EN
    chk("stat_ops", stat_ops, {32'd3, 32'd3});
    chk("stat_stall_fair", stat_stall, 0);
`endif

    // Backpressure: owner withholds resp_rdy for 10 cycles
    do_reset();
    req_val = 2'b10; req_fn = 2'b10; req_a = {32'hFFFF_FF9C, 32'h0}; req_b = {32'd7, 32'h0};
    issue(1, 32'hFFFF_FF9C);
    req_val = 2'b11;
    serve(1, div_ref(1, 32'hFFFF_FF9C, 7), 10);

    // Lock: port1 stalled by the divider keeps its grant after port0 arrives
    do_reset();
    req_val = 2'b10; req_fn = 2'b00; req_a = {32'd77, 32'd33}; req_b = {32'd5, 32'd4};
    #1;
    chk("lock_pre_dv", div_req_val, 1);
    chk("lock_pre_a", div_req_a, 77);
    @(posedge clk); #1;
    req_val = 2'b11;
    #1;
    chk("lock_hold_rdy", req_rdy, 0);
    chk("lock_hold_a", div_req_a, 77);
    @(posedge clk); #1;
    issue(1, 32'd77);
    req_val = 2'b01;
    serve(1, div_ref(0, 77, 5), 0);
    issue(0, 32'd33);
    req_val = 2'b00;
    serve(0, div_ref(0, 33, 4), 0);
`ifdef IMULDIV_DIV_ARB_STATS_EN
    chk("stat_stall_lock", stat_stall, 2);
`endif

    // Reset while busy with rr_ptr pointing at port 1
    do_reset();
    req_val = 2'b01; req_a = {32'd60, 32'd50}; req_b = {32'd3, 32'd2};
    issue(0, 32'd50);
    req_val = 2'b00;
    serve(0, div_ref(0, 50, 2), 0);
    req_val = 2'b10;
    issue(1, 32'd60);
    req_val = 2'b11;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req_val = 2'b00; div_resp_val = 1'b1; resp_rdy = 2'b11;
    #1;
    chk("rstbusy_resp_val", resp_val, 0);
    chk("rstbusy_div_resp_rdy", div_resp_rdy, 0);
    chk("rstbusy_div_req_val", div_req_val, 0);
    chk("rstbusy_req_rdy", req_rdy, 0);
    div_resp_val = 1'b0; resp_rdy = 2'b00; req_val = 2'b11;
    issue(0, 32'd50);
    req_val = 2'b00;
    serve(0, div_ref(0, 50, 2), 1);

    // Randomized traffic against the reference model
    do_reset();
    pref = 0; mbusy = 0; mlock = 0; req_fire_l = 0; resp_fire_l = 0;
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (req_fire_l) begin
        pend[fire_port] = 0;
        mbusy = 1; mowner = fire_port;
        dres = div_ref(pfn[fire_port], pa[fire_port], pb[fire_port]);
        dlat = $urandom_range(0, 3);
        div_resp_val = 1'b0;
      end
      if (resp_fire_l) begin
        mbusy = 0; div_resp_val = 1'b0;
        pref = (mowner + 1) % 2;
      end
      if (mbusy && !div_resp_val) begin
        if (dlat == 0) begin
          div_resp_val = 1'b1; div_resp_result = dres;
        end else dlat--;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          pa[p] = $urandom;
          pb[p] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : -32'($urandom_range(1, 1000));
          pfn[p] = 1'($urandom_range(0, 1));
        end
      end
      req_val = {pend[1], pend[0]};
      req_fn = {pfn[1], pfn[0]};
      req_a = {pa[1], pa[0]};
      req_b = {pb[1], pb[0]};
      div_req_rdy = 1'($urandom_range(0, 1));
      resp_rdy = 2'($urandom_range(0, 3));
      #1;
      req_fire_l = 0; resp_fire_l = 0;
      if (!mbusy) begin
        any = pend[0] | pend[1];
        chk("rnd_div_req_val", div_req_val, any);
        chk("rnd_idle_resp_val", resp_val, 0);
        if (any) begin
          if (mlock) ep = mlock_port;
          else ep = pend[pref] ? pref : (pref + 1) % 2;
          chk("rnd_a", div_req_a, pa[ep]);
          chk("rnd_b", div_req_b, pb[ep]);
          chk("rnd_fn", div_req_fn, pfn[ep]);
          chk("rnd_req_rdy", req_rdy, div_req_rdy ? (64'(1) << ep) : 64'(0));
          if (div_req_rdy) begin
            req_fire_l = 1; fire_port = ep; mlock = 0;
          end else begin
            mlock = 1; mlock_port = ep;
          end
        end
      end else begin
        chk("rnd_busy_req_rdy", req_rdy, 0);
        chk("rnd_busy_div_req_val", div_req_val, 0);
        chk("rnd_resp_val", resp_val, div_resp_val ? (64'(1) << mowner) : 64'(0));
        chk("rnd_div_resp_rdy", div_resp_rdy, resp_rdy[mowner]);
        if (div_resp_val) begin
          chk("rnd_result", resp_result, dres);
          if (resp_rdy[mowner]) resp_fire_l = 1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
